// File: rtl/tdc_time_encoder.sv
// TDC back end: popcount-encodes start/stop thermometer words and counts coarse periods between them.
// One timestamped result per hit. oValid fires 3 edges after stop capture or saturation.
module tdc_time_encoder #(
  parameter int NUM_TAPS = 120,
  parameter int FINE_W   = 7,
  parameter int COARSE_W = 16
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStartValid,
  input  logic [NUM_TAPS-1:0] iStartTaps,
  input  logic                iStopValid,
  input  logic [NUM_TAPS-1:0] iStopTaps,
  output logic                oValid,
  output logic [FINE_W-1:0]   oFineStart,
  output logic [FINE_W-1:0]   oFineStop,
  output logic [COARSE_W-1:0] oCoarse,
  output logic                oOverflow,
  output logic                oBusy,
  output logic                oError
);

  localparam int NGRP  = (NUM_TAPS + 7) / 8;
  localparam int PAD_W = NGRP * 8;
  localparam logic [COARSE_W-1:0] COARSE_LAST = COARSE_W'((1 << COARSE_W) - 2);

  typedef enum logic [1:0] {IDLE, RUN, ENCODE} state_t;

  state_t              state, state_next;
  logic [1:0]          phase;
  logic                start_acc, stop_acc, sat, err_next, done;
  logic [NUM_TAPS-1:0] start_word, stop_word;
  logic [PAD_W-1:0]    start_pad, stop_pad;
  logic [COARSE_W-1:0] coarse;
  logic                overflow;
  logic [3:0]          grp_start [NGRP];
  logic [3:0]          grp_stop  [NGRP];
  logic [3:0]          grp_start_c [NGRP];
  logic [3:0]          grp_stop_c  [NGRP];
  logic [FINE_W-1:0]   sum_start, sum_stop, sum_start_c, sum_stop_c;

  function automatic logic [3:0] pop8(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, b[i]};
    return n;
  endfunction

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_next;
      phase <= (state == ENCODE) ? phase + 2'd1 : 2'd0;
    end
  end

  // Stop wins over saturation when both land on the same edge.
  always_comb begin
    state_next = state;
    start_acc  = 1'b0;
    stop_acc   = 1'b0;
    sat        = 1'b0;
    err_next   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (iStartValid) begin
          start_acc = 1'b1;
          if (iStopValid) begin
            stop_acc   = 1'b1;
            state_next = ENCODE;
          end else begin
            state_next = RUN;
          end
        end else if (iStopValid) begin
          err_next = 1'b1;
        end
      end
      RUN: begin
        err_next = iStartValid;
        if (iStopValid) begin
          stop_acc   = 1'b1;
          state_next = ENCODE;
        end else if (coarse == COARSE_LAST) begin
          sat        = 1'b1;
          state_next = ENCODE;
        end
      end
      ENCODE: begin
        err_next = iStartValid | iStopValid;
        if (phase == 2'd2) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      start_word <= '0;
      stop_word  <= '0;
      coarse     <= '0;
      overflow   <= 1'b0;
    end else begin
      if (start_acc) begin
        start_word <= iStartTaps;
        coarse     <= '0;
        overflow   <= 1'b0;
      end else if (state == RUN) begin
        coarse <= coarse + COARSE_W'(1);
      end
      if (stop_acc) begin
        stop_word <= iStopTaps;
      end else if (sat) begin
        stop_word <= '0;
        overflow  <= 1'b1;
      end
    end
  end

  assign start_pad = PAD_W'(start_word);
  assign stop_pad  = PAD_W'(stop_word);

  always_comb begin
    for (int g = 0; g < NGRP; g++) begin
      grp_start_c[g] = pop8(start_pad[g*8 +: 8]);
      grp_stop_c[g]  = pop8(stop_pad[g*8 +: 8]);
    end
  end

  always_comb begin
    sum_start_c = '0;
    sum_stop_c  = '0;
    for (int g = 0; g < NGRP; g++) begin
      sum_start_c = sum_start_c + FINE_W'(grp_start[g]);
      sum_stop_c  = sum_stop_c + FINE_W'(grp_stop[g]);
    end
  end

  // Two-stage popcount: 8-bit group sums, then the final adder tree.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int g = 0; g < NGRP; g++) begin
        grp_start[g] <= '0;
        grp_stop[g]  <= '0;
      end
      sum_start <= '0;
      sum_stop  <= '0;
    end else if (state == ENCODE) begin
      for (int g = 0; g < NGRP; g++) begin
        grp_start[g] <= grp_start_c[g];
        grp_stop[g]  <= grp_stop_c[g];
      end
      sum_start <= sum_start_c;
      sum_stop  <= sum_stop_c;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oValid     <= 1'b0;
      oFineStart <= '0;
      oFineStop  <= '0;
      oCoarse    <= '0;
      oOverflow  <= 1'b0;
      oBusy      <= 1'b0;
      oError     <= 1'b0;
    end else begin
      oValid <= done;
      oBusy  <= (state_next != IDLE);
      oError <= err_next;
      if (done) begin
        oFineStart <= sum_start;
        oFineStop  <= sum_stop;
        oCoarse    <= coarse;
        oOverflow  <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_tdc_time_encoder.sv
// Randomized and directed bench for tdc_time_encoder; expected results come from
// popcounts and strobe timing computed here.
module tb_tdc_time_encoder;
  localparam int NT = 120;
  localparam int FW = 7;

  logic          clk, rst;
  logic          start_v, stop_v;
  logic [NT-1:0] start_t, stop_t;

  logic          valid, ovf, busy, err;
  logic [FW-1:0] fs, fp;
  logic [15:0]   coarse;

  logic          valid4, ovf4, busy4, err4;
  logic [FW-1:0] fs4, fp4;
  logic [3:0]    coarse4;

  int checks = 0;
  int errors = 0;

  tdc_time_encoder #(.NUM_TAPS(NT), .FINE_W(FW), .COARSE_W(16)) dut (
    .iClk(clk), .iRst(rst),
    .iStartValid(start_v), .iStartTaps(start_t),
    .iStopValid(stop_v), .iStopTaps(stop_t),
    .oValid(valid), .oFineStart(fs), .oFineStop(fp), .oCoarse(coarse),
    .oOverflow(ovf), .oBusy(busy), .oError(err)
  );

  tdc_time_encoder #(.NUM_TAPS(NT), .FINE_W(FW), .COARSE_W(4)) dut4 (
    .iClk(clk), .iRst(rst),
    .iStartValid(start_v), .iStartTaps(start_t),
    .iStopValid(stop_v), .iStopTaps(stop_t),
    .oValid(valid4), .oFineStart(fs4), .oFineStop(fp4), .oCoarse(coarse4),
    .oOverflow(ovf4), .oBusy(busy4), .oError(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NT-1:0] ones(input int n);
    logic [NT-1:0] w;
    w = '0;
    for (int i = 0; i < NT; i++) if (i < n) w[i] = 1'b1;
    return w;
  endfunction

  // Thermometer word with an optional bubble near the transition.
  function automatic logic [NT-1:0] rand_therm();
    logic [NT-1:0] w;
    int n, p;
    n = $urandom_range(0, NT);
    w = ones(n);
    if ($urandom_range(0, 1) == 1) begin
      p = n + $urandom_range(0, 6) - 3;
      if (p >= 0 && p < NT) w[p] = ~w[p];
    end
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start_v = 1'b0; stop_v = 1'b0;
    start_t = '0; stop_t = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Start captured at edge Ts, stop at Ts+gap (gap 0 = same strobe cycle); result on edge T+3.
  task automatic run_meas(input logic [NT-1:0] sw, input logic [NT-1:0] pw, input int gap);
    int exp_fs, exp_fp;
    exp_fs = $countones(sw);
    exp_fp = $countones(pw);
    start_v = 1'b1; start_t = sw;
    if (gap == 0) begin stop_v = 1'b1; stop_t = pw; end
    tick();
    start_v = 1'b0; stop_v = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %0b want 1", busy); end
    if (gap > 0) begin
      repeat (gap - 1) tick();
      stop_v = 1'b1; stop_t = pw;
      tick();
      stop_v = 1'b0;
    end
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++;
      if (valid !== 1'b0) begin errors++; $display("FAIL early_valid: T+%0d got %0b want 0", k, valid); end
    end
    tick();
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL valid_T3: got %0b want 1", valid); end
    checks++;
    if (fs !== FW'(exp_fs)) begin errors++; $display("FAIL fine_start: got %0d want %0d", fs, exp_fs); end
    checks++;
    if (fp !== FW'(exp_fp)) begin errors++; $display("FAIL fine_stop: got %0d want %0d", fp, exp_fp); end
    checks++;
    if (coarse !== 16'(gap)) begin errors++; $display("FAIL coarse: got %0d want %0d", coarse, gap); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL overflow: got %0b want 0", ovf); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_valid: got %0b want 0", busy); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({valid, fs, fp, coarse, ovf, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v%0b fs%0d fp%0d c%0d o%0b b%0b e%0b want all 0",
               valid, fs, fp, coarse, ovf, busy, err);
    end
  endtask

  task automatic test_directed();
    logic [NT-1:0] w;
    run_meas(ones(40), ones(85), 5);
    w = '0; w[0] = 1'b1; w[1] = 1'b1; w[2] = 1'b1; w[4] = 1'b1;
    run_meas(w, ones(NT), 2);
    run_meas(ones(10), ones(20), 0);
    tick();
    checks++;
    if (valid !== 1'b0 || fs !== FW'(10) || fp !== FW'(20) || coarse !== 16'd0) begin
      errors++;
      $display("FAIL hold_after_valid: got v%0b fs%0d fp%0d c%0d want v0 fs10 fp20 c0",
               valid, fs, fp, coarse);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 25; i++) begin
      run_meas(rand_therm(), rand_therm(), $urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  task automatic test_errors();
    logic [NT-1:0] sw;
    sw = rand_therm();
    stop_v = 1'b1; stop_t = ones(7);
    tick();
    stop_v = 1'b0;
    checks++;
    if (err !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_stop: got e%0b v%0b b%0b want e1 v0 b0", err, valid, busy);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_pulse_len: got %0b want 0", err); end
    start_v = 1'b1; start_t = sw;
    tick();
    start_v = 1'b0;
    tick(); tick();
    start_v = 1'b1; start_t = ones(3);
    tick();
    start_v = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_restart: got e%0b b%0b want e1 b1", err, busy);
    end
    tick();
    stop_v = 1'b1; stop_t = ones(50);
    tick();
    stop_v = 1'b0;
    tick();
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    checks++;
    if (err !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL encode_strobe: got e%0b v%0b want e1 v0", err, valid);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || fs !== FW'($countones(sw)) || fp !== FW'(50) || coarse !== 16'd5 || err !== 1'b0) begin
      errors++;
      $display("FAIL run_after_errors: got v%0b fs%0d fp%0d c%0d e%0b want v1 fs%0d fp50 c5 e0",
               valid, fs, fp, coarse, err, $countones(sw));
    end
    tick();
  endtask

  task automatic test_overflow();
    int k_seen;
    logic [NT-1:0] sw;
    do_reset();
    sw = rand_therm();
    start_v = 1'b1; start_t = sw;
    tick();
    start_v = 1'b0;
    k_seen = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (valid4 === 1'b1) begin k_seen = k; break; end
    end
    checks++;
    if (k_seen != 18) begin errors++; $display("FAIL ovf_latency: got %0d want 18", k_seen); end
    checks++;
    if (ovf4 !== 1'b1 || coarse4 !== 4'd15 || fp4 !== '0 || fs4 !== FW'($countones(sw))) begin
      errors++;
      $display("FAIL ovf_fields: got o%0b c%0d fp%0d fs%0d want o1 c15 fp0 fs%0d",
               ovf4, coarse4, fp4, fs4, $countones(sw));
    end
    checks++;
    if (busy4 !== 1'b0) begin errors++; $display("FAIL ovf_idle: got busy %0b want 0", busy4); end
    tick();
    checks++;
    if (valid4 !== 1'b0 || ovf4 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pulse: got v%0b o%0b want v0 o1", valid4, ovf4);
    end
    stop_v = 1'b1; stop_t = ones(4);
    tick();
    stop_v = 1'b0;
    checks++;
    if (err4 !== 1'b1) begin errors++; $display("FAIL ovf_back_idle: got err %0b want 1", err4); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int seen;
    start_v = 1'b1; start_t = ones(33);
    tick();
    start_v = 1'b0;
    tick(); tick();
    stop_v = 1'b1; stop_t = ones(66);
    tick();
    stop_v = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({valid, fs, fp, coarse, ovf, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got v%0b fs%0d fp%0d c%0d o%0b b%0b e%0b want all 0",
               valid, fs, fp, coarse, ovf, busy, err);
    end
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_drop: got %0d valids want 0", seen); end
    run_meas(rand_therm(), rand_therm(), $urandom_range(1, 20));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_errors();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
